// File: rtl/tmds_pkg.sv
`default_nettype none
// tmds_pkg: TMDS control-token constants and word-alignment FSM encoding. Rev 1.0
package tmds_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_t;

  // Bit offsets cover the ten alignments of a 10-bit character.
  function automatic logic [3:0] next_offset(input logic [3:0] off);
    return (off == 4'd9) ? 4'd0 : off + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_token_detect.sv
`default_nettype none
// tmds_token_detect: flags a 10-bit word equal to any of the four TMDS control tokens. Rev 1.0
module tmds_token_detect
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic       hit
);

  always_comb begin
    hit = (word == TMDS_CTRL_00) || (word == TMDS_CTRL_01) ||
          (word == TMDS_CTRL_10) || (word == TMDS_CTRL_11);
  end

endmodule
`default_nettype wire

// File: rtl/deserializer_1_to_10.sv
`default_nettype none
// deserializer_1_to_10: TMDS 1:10 deserializer in the 5x serial clock domain with
// control-token word alignment and lock reporting. Rev 1.0
module deserializer_1_to_10
  import tmds_pkg::*;
#(
  parameter int LOCK_CNT     = 8,
  parameter int SEARCH_WORDS = 2048,
  parameter int LOSS_WORDS   = 4096
) (
  input  logic       serial_clk_5x,
  input  logic       rst_n,
  input  logic       datain_rise,
  input  logic       datain_fall,
  output logic [9:0] paralell_data,
  output logic       data_valid,
  output logic       ctrl_token,
  output logic       locked,
  output logic [3:0] bit_offset
);

  localparam int RUN_W    = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int MISS_MAX = (SEARCH_WORDS > LOSS_WORDS) ? SEARCH_WORDS : LOSS_WORDS;
  localparam int MISS_W   = (MISS_MAX > 1) ? $clog2(MISS_MAX) : 1;

  localparam logic [RUN_W-1:0]  RUN_LAST    = RUN_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] SEARCH_LAST = MISS_W'(SEARCH_WORDS - 1);
  localparam logic [MISS_W-1:0] LOSS_LAST   = MISS_W'(LOSS_WORDS - 1);

  logic [19:0]       sr;
  logic [2:0]        phase_cnt;
  logic              word_evt;
  logic [9:0]        window;
  logic              token_hit;

  align_state_t      state, state_nxt;
  logic [RUN_W-1:0]  run_cnt, run_nxt, run_inc;
  logic [MISS_W-1:0] miss_cnt, miss_nxt, miss_inc;
  logic [3:0]        offset_nxt;
  logic              locked_nxt;

  assign word_evt = (phase_cnt == 3'd4);
  assign window   = 10'(sr >> bit_offset);

  tmds_token_detect u_token_detect (
    .word (window),
    .hit  (token_hit)
  );

  // Serial capture and word strobe; the window samples sr before this edge's shift.
  always_ff @(posedge serial_clk_5x or negedge rst_n) begin
    if (!rst_n) begin
      sr            <= '0;
      phase_cnt     <= '0;
      paralell_data <= '0;
      data_valid    <= 1'b0;
      ctrl_token    <= 1'b0;
    end else begin
      sr         <= {datain_fall, datain_rise, sr[19:2]};
      phase_cnt  <= word_evt ? 3'd0 : phase_cnt + 3'd1;
      data_valid <= word_evt;
      if (word_evt) begin
        paralell_data <= window;
        ctrl_token    <= token_hit;
      end
    end
  end

  always_ff @(posedge serial_clk_5x or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SEARCH;
      run_cnt    <= '0;
      miss_cnt   <= '0;
      bit_offset <= '0;
      locked     <= 1'b0;
    end else begin
      state      <= state_nxt;
      run_cnt    <= run_nxt;
      miss_cnt   <= miss_nxt;
      bit_offset <= offset_nxt;
      locked     <= locked_nxt;
    end
  end

  assign run_inc  = (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
  assign miss_inc = (miss_cnt == '1) ? miss_cnt : miss_cnt + 1'b1;

  always_comb begin
    state_nxt  = state;
    run_nxt    = run_cnt;
    miss_nxt   = miss_cnt;
    offset_nxt = bit_offset;
    locked_nxt = locked;
    if (word_evt) begin
      case (state)
        ST_SEARCH: begin
          if (token_hit) begin
            state_nxt = ST_VERIFY;
            run_nxt   = RUN_W'(1);
            miss_nxt  = '0;
          end else if (miss_cnt == SEARCH_LAST) begin
            offset_nxt = next_offset(bit_offset);
            miss_nxt   = '0;
          end else begin
            miss_nxt = miss_inc;
          end
        end
        ST_VERIFY: begin
          if (token_hit) begin
            if (run_cnt == RUN_LAST) begin
              state_nxt  = ST_LOCKED;
              locked_nxt = 1'b1;
            end else begin
              run_nxt = run_inc;
            end
          end else begin
            state_nxt  = ST_SEARCH;
            offset_nxt = next_offset(bit_offset);
            run_nxt    = '0;
            miss_nxt   = '0;
          end
        end
        ST_LOCKED: begin
          // Only a long token drought drops lock; the offset is kept for re-acquisition.
          if (token_hit) begin
            miss_nxt = '0;
          end else if (miss_cnt == LOSS_LAST) begin
            state_nxt  = ST_SEARCH;
            locked_nxt = 1'b0;
            miss_nxt   = '0;
          end else begin
            miss_nxt = miss_inc;
          end
        end
        default: state_nxt = ST_SEARCH;
      endcase
    end
  end

endmodule
`default_nettype wire
